// File: rtl/pwm_capture_if.sv
// Signal bundle for the PWM capture channel.
//   master : drives cap_en / pwm_in and observes the measurement outputs
//   slave  : the capture block itself
// Signals:
//   cap_en      capture enable (low forces the capture FSM to IDLE)
//   pwm_in      PWM waveform, may be asynchronous to clk
//   meas_value  high cycles in the last complete period
//   meas_range  last complete period length minus 1
//   meas_valid  one-cycle pulse when meas_value/meas_range update
//   meas_stuck  sticky flag: no rising edge seen for 2^W cycles
//   stuck_level synchronized input level when meas_stuck was set
//   dbg_state   current capture FSM state (0 IDLE, 1 SYNC, 2 MEAS)
interface pwm_capture_if #(
    parameter int W = 8
);
    logic         cap_en;
    logic         pwm_in;
    logic [W-1:0] meas_value;
    logic [W-1:0] meas_range;
    logic         meas_valid;
    logic         meas_stuck;
    logic         stuck_level;
    logic [1:0]   dbg_state;

    modport master (
        output cap_en, pwm_in,
        input  meas_value, meas_range, meas_valid, meas_stuck, stuck_level, dbg_state
    );

    modport slave (
        input  cap_en, pwm_in,
        output meas_value, meas_range, meas_valid, meas_stuck, stuck_level, dbg_state
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: samples a PWM waveform and recovers its duty (high-cycle count)
// and period (length - 1) as a value/range pair, matching the generator-side
// encoding. A constant input (0% / 100% duty) raises a sticky stuck flag.
// Ports:
//   clk    single clock, all logic on posedge
//   reset  asynchronous, active-high
//   bus    pwm_capture_if.slave (cap_en, pwm_in in; measurement outputs and
//          FSM state out)
// Interface protocol: meas_valid is a one-cycle qualifier with no back-pressure;
// meas_value/meas_range are stable between pulses and are meaningful only once
// at least one pulse has been seen since reset.
module pwm_capture #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    pwm_capture_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        MEAS = 2'd2
    } state_t;

    localparam logic [W-1:0] CNT_MAX = '1;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_dly_q;
    logic [W-1:0]           per_cnt_q, per_cnt_d;
    logic [W-1:0]           high_cnt_q, high_cnt_d;
    logic [W-1:0]           meas_value_q, meas_value_d;
    logic [W-1:0]           meas_range_q, meas_range_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   meas_stuck_q, meas_stuck_d;
    logic                   stuck_level_q, stuck_level_d;

    logic s;
    logic rise;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_dly_q;

    // Synchronizer and edge-detect delay run regardless of capture state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            s_dly_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
            s_dly_q <= s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            per_cnt_q     <= '0;
            high_cnt_q    <= '0;
            meas_value_q  <= '0;
            meas_range_q  <= '0;
            meas_valid_q  <= 1'b0;
            meas_stuck_q  <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            per_cnt_q     <= per_cnt_d;
            high_cnt_q    <= high_cnt_d;
            meas_value_q  <= meas_value_d;
            meas_range_q  <= meas_range_d;
            meas_valid_q  <= meas_valid_d;
            meas_stuck_q  <= meas_stuck_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        per_cnt_d     = per_cnt_q;
        high_cnt_d    = high_cnt_q;
        meas_value_d  = meas_value_q;
        meas_range_d  = meas_range_q;
        meas_valid_d  = 1'b0;
        meas_stuck_d  = meas_stuck_q;
        stuck_level_d = stuck_level_q;

        if (!bus.cap_en) begin
            state_d       = IDLE;
            per_cnt_d     = '0;
            high_cnt_d    = '0;
            meas_stuck_d  = 1'b0;
            stuck_level_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = SYNC;
                    per_cnt_d  = '0;
                    high_cnt_d = '0;
                end
                SYNC, MEAS: begin
                    // A rise wins over the timeout so a period of exactly
                    // 2^W cycles is still a valid measurement.
                    if (rise) begin
                        if (state_q == MEAS) begin
                            meas_value_d = high_cnt_q;
                            meas_range_d = per_cnt_q;
                            meas_valid_d = 1'b1;
                            meas_stuck_d = 1'b0;
                        end
                        state_d    = MEAS;
                        per_cnt_d  = '0;
                        high_cnt_d = {{(W-1){1'b0}}, 1'b1};
                    end else if (per_cnt_q == CNT_MAX) begin
                        meas_stuck_d  = 1'b1;
                        stuck_level_d = s;
                        state_d       = SYNC;
                        per_cnt_d     = '0;
                        high_cnt_d    = '0;
                    end else begin
                        per_cnt_d = per_cnt_q + 1'b1;
                        if (state_q == MEAS) begin
                            high_cnt_d = high_cnt_q + {{(W-1){1'b0}}, s};
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    per_cnt_d  = '0;
                    high_cnt_d = '0;
                end
            endcase
        end
    end

    assign bus.meas_value  = meas_value_q;
    assign bus.meas_range  = meas_range_q;
    assign bus.meas_valid  = meas_valid_q;
    assign bus.meas_stuck  = meas_stuck_q;
    assign bus.stuck_level = stuck_level_q;
    assign bus.dbg_state   = state_q;
endmodule
